// File: rtl/types.sv
// Shared types for the instruction fetch stage: decode payload, fetch FSM states
// and the default reset fetch address.
package types;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] ia_plus_4;
   } id_params_t;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_FLUSH = 2'd2
   } if_state_e;

   localparam logic [31:0] RESET_IA_DEFAULT = 32'h0000_0000;

   function automatic logic [31:0] ia_next(input logic [31:0] ia);
      return ia + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order fetch queue: an entry is allocated at request handshake and
// filled by its response; the head is presented to decode once filled.
module fetch_queue
   import types::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        alloc,
   input  logic [31:0] alloc_ia_plus_4,
   input  logic        fill,
   input  logic [31:0] fill_ir,
   input  logic        pop,
   output logic [1:0]  count,
   output logic [1:0]  filled,
   output logic        head_filled,
   output id_params_t  head_params
);

   logic [31:0] ir_mem   [2];
   logic [31:0] iap4_mem [2];
   logic        head;
   logic [1:0]  cnt;
   logic [1:0]  fcnt;
   logic        tail_idx;
   logic        fill_idx;

   // Fills complete in order, so the oldest unfilled entry sits fcnt slots past the head.
   assign tail_idx    = head ^ cnt[0];
   assign fill_idx    = head ^ fcnt[0];
   assign count       = cnt;
   assign filled      = fcnt;
   assign head_filled = (fcnt != 2'd0);
   assign head_params = '{ir: ir_mem[head], ia_plus_4: iap4_mem[head]};

   always_ff @(posedge clk) begin
      if (rst) begin
         head <= 1'b0;
         cnt  <= 2'd0;
         fcnt <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            ir_mem[i]   <= '0;
            iap4_mem[i] <= '0;
         end
      end else if (flush) begin
         cnt  <= 2'd0;
         fcnt <= 2'd0;
      end else begin
         if (alloc) iap4_mem[tail_idx] <= alloc_ia_plus_4;
         if (fill)  ir_mem[fill_idx]   <= fill_ir;
         if (pop)   head               <= ~head;
         cnt  <= cnt  + {1'b0, alloc} - {1'b0, pop};
         fcnt <= fcnt + {1'b0, fill}  - {1'b0, pop};
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with 2-credit flow control and branch redirect/discard.
// Define MINA_IF_BYPASS_EN to forward a response straight to decode when the queue head is waiting for it.
module if_stage
   import types::*;
#(
   parameter logic [31:0] RESET_IA = RESET_IA_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        id_valid,
   input  logic        id_ready,
   output id_params_t  id_params,
   input  logic        branch_req,
   input  logic [31:0] branch_ia
);

   if_state_e   state;
   logic [31:0] ia;
   logic [1:0]  disc;
   logic [1:0]  q_count;
   logic [1:0]  q_filled;
   logic        head_filled;
   id_params_t  head_params;
   logic        req_hs;
   logic        pop;
   logic        branch_taken;
   logic        rsp_drop;
   logic        rsp_take;
   logic [1:0]  disc_dec;
   logic [1:0]  disc_branch;

   assign imem_req_addr  = ia;
   assign imem_req_valid = !rst && (state == S_FETCH) && (({1'b0, q_count} + {1'b0, disc}) < 3'd2);
   assign req_hs         = imem_req_valid && imem_req_ready;
   assign pop            = id_valid && id_ready;
   assign branch_taken   = branch_req && pop;
   assign rsp_drop       = imem_rsp_valid && ((disc != 2'd0) || branch_taken);
   assign rsp_take       = imem_rsp_valid && !rsp_drop;
   assign disc_dec       = disc - {1'b0, rsp_drop};
   // Everything still owed by memory at the redirect, minus a response landing this very cycle.
   assign disc_branch    = q_count - q_filled + {1'b0, req_hs} - {1'b0, imem_rsp_valid};

`ifdef MINA_IF_BYPASS_EN
   logic bypass;
   assign bypass = imem_rsp_valid && (disc == 2'd0) && (q_count != 2'd0) && (q_filled == 2'd0);
`endif

   always_comb begin
      id_valid  = 1'b0;
      id_params = '0;
      if (!rst && head_filled) begin
         id_valid  = 1'b1;
         id_params = head_params;
      end
`ifdef MINA_IF_BYPASS_EN
      else if (!rst && bypass) begin
         id_valid            = 1'b1;
         id_params.ir        = imem_rsp_data;
         id_params.ia_plus_4 = head_params.ia_plus_4;
      end
`endif
   end

   fetch_queue u_queue (
      .clk             (clk),
      .rst             (rst),
      .flush           (branch_taken),
      .alloc           (req_hs),
      .alloc_ia_plus_4 (ia_next(ia)),
      .fill            (rsp_take),
      .fill_ir         (imem_rsp_data),
      .pop             (pop),
      .count           (q_count),
      .filled          (q_filled),
      .head_filled     (head_filled),
      .head_params     (head_params)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_BOOT;
         ia    <= RESET_IA;
         disc  <= 2'd0;
      end else begin
         if (branch_taken) ia <= branch_ia & ~32'd3;
         else if (req_hs)  ia <= ia_next(ia);
         case (state)
            S_BOOT:  state <= S_FETCH;
            S_FETCH: begin
               if (branch_taken) begin
                  state <= S_FLUSH;
                  disc  <= disc_branch;
               end
            end
            S_FLUSH: begin
               disc <= disc_dec;
               if (disc_dec == 2'd0) state <= S_FETCH;
            end
            default: state <= S_BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: memory model with configurable latency, an
// architectural fetch-stream model checked every cycle, and directed scenarios.
module tb_if_stage;
   import types::*;

   localparam logic [31:0] RST_IA = 32'h0000_0000;
`ifdef MINA_IF_BYPASS_EN
   localparam int RSP_TO_IDV = 0;
`else
   localparam int RSP_TO_IDV = 1;
`endif

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = '0;
   logic        id_valid;
   logic        id_ready;
   id_params_t  id_params;
   logic        branch_req;
   logic [31:0] branch_ia;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          mem_lat = 1;
   mreq_t       memq[$];
   logic [31:0] exp_ia, exp_req;
   logic [31:0] req_log[$];
   int          req_cyc_log[$];
   logic [31:0] dlv_log[$];
   logic [31:0] dlv_ir_log[$];
   int          rel_cyc = 0;
   int          first_rsp_cyc = -1;
   int          first_idv_cyc = -1;
   int          br_cyc = -1;

   always #5 clk = ~clk;

   if_stage #(.RESET_IA(RST_IA)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_params      (id_params),
      .branch_req     (branch_req),
      .branch_ia      (branch_ia)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
      if (i >= 0 && i < q.size()) return q[i];
      return 32'hxxxx_xxxx;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory responds in order mem_lat cycles after handshake; the model tracks the
   // architectural instruction stream and the expected request address stream.
   always @(negedge clk) begin
      cyc++;
      #1;
      if (rst) begin
         memq.delete();
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end else if (memq.size() > 0 && memq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(memq[0].addr);
         void'(memq.pop_front());
         if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
      #1;
      if (rst) begin
         checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
         checkOutput("rst_id_valid", 32'(id_valid), 32'd0);
         checkOutput("rst_id_ir", id_params.ir, 32'd0);
         checkOutput("rst_id_iap4", id_params.ia_plus_4, 32'd0);
         exp_ia = RST_IA;
         exp_req = RST_IA;
         rel_cyc = cyc + 1;
         first_rsp_cyc = -1;
         first_idv_cyc = -1;
         req_log.delete();
         req_cyc_log.delete();
         dlv_log.delete();
         dlv_ir_log.delete();
      end else begin
         if (imem_req_valid) checkOutput("req_addr", imem_req_addr, exp_req);
         if (id_valid) begin
            if (first_idv_cyc < 0) first_idv_cyc = cyc;
            checkOutput("id_ir", id_params.ir, mem_word(exp_ia));
            checkOutput("id_ia_plus_4", id_params.ia_plus_4, exp_ia + 32'd4);
         end
         if (imem_req_valid && imem_req_ready) begin
            memq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
            req_log.push_back(imem_req_addr);
            req_cyc_log.push_back(cyc);
            exp_req = exp_req + 32'd4;
         end
         if (id_valid && id_ready) begin
            dlv_log.push_back(id_params.ia_plus_4);
            dlv_ir_log.push_back(id_params.ir);
            exp_ia = exp_ia + 32'd4;
            if (branch_req) begin
               exp_ia  = branch_ia & ~32'd3;
               exp_req = branch_ia & ~32'd3;
               br_cyc  = cyc;
            end
         end
      end
   end

   task automatic applyStimulus(input logic rdy, input logic br, input logic [31:0] bia, input int n);
      id_ready   = rdy;
      branch_req = br;
      branch_ia  = bia;
      repeat (n) @(negedge clk);
   endtask

   task automatic doReset(input int n);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   // Hold a branch request until decode accepts an instruction, then release it.
   task automatic doBranch(input logic [31:0] target);
      br_cyc = -1;
      id_ready   = 1'b1;
      branch_req = 1'b1;
      branch_ia  = target;
      for (int i = 0; i < 20 && br_cyc < 0; i++) @(negedge clk);
      branch_req = 1'b0;
      if (br_cyc < 0) checkOutput("branch_taken_timeout", 32'd0, 32'd1);
   endtask

   function automatic int first_req_after(input int c);
      for (int i = 0; i < req_cyc_log.size(); i++)
         if (req_cyc_log[i] > c) return i;
      return -1;
   endfunction

   initial begin
      int k;
      rst = 1'b1;
      imem_req_ready = 1'b1;
      id_ready = 1'b1;
      branch_req = 1'b0;
      branch_ia = '0;

      // Basic streaming from reset with 1-cycle memory
      mem_lat = 1;
      doReset(3);
      applyStimulus(1'b1, 1'b0, 32'd0, 10);
      checkOutput("a_req0", qget(req_log, 0), 32'h0);
      checkOutput("a_req1", qget(req_log, 1), 32'h4);
      checkOutput("a_req2", qget(req_log, 2), 32'h8);
      checkOutput("a_first_req_cycle", 32'(req_cyc_log.size() > 0 ? req_cyc_log[0] - rel_cyc : -1), 32'd1);
      checkOutput("a_dlv0", qget(dlv_log, 0), 32'h4);
      checkOutput("a_dlv1", qget(dlv_log, 1), 32'h8);
      checkOutput("a_dlv2", qget(dlv_log, 2), 32'hC);
      checkOutput("a_ir0", qget(dlv_ir_log, 0), 32'h5A5A_A5A5);
      checkOutput("a_ir2", qget(dlv_ir_log, 2), 32'h5A5A_A5AD);
      checkOutput("a_rsp_to_idv", 32'(first_idv_cyc - first_rsp_cyc), 32'(RSP_TO_IDV));

      // Decode stalled: exactly two requests, then both delivered in order
      id_ready = 1'b0;
      doReset(2);
      applyStimulus(1'b0, 1'b0, 32'd0, 12);
      checkOutput("b_req_count", 32'(req_log.size()), 32'd2);
      checkOutput("b_req_valid_low", 32'(imem_req_valid), 32'd0);
      checkOutput("b_no_dlv", 32'(dlv_log.size()), 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0, 6);
      checkOutput("b_dlv0", qget(dlv_log, 0), 32'h4);
      checkOutput("b_dlv1", qget(dlv_log, 1), 32'h8);
      checkOutput("b_req2", qget(req_log, 2), 32'h8);

      // Redirect to an unaligned target with a request in flight
      doReset(2);
      doBranch(32'h0000_1003);
      applyStimulus(1'b1, 1'b0, 32'd0, 8);
      checkOutput("c_dropped_req", qget(req_log, 1), 32'h4);
      k = first_req_after(br_cyc);
      checkOutput("c_req_after_br", qget(req_log, k), 32'h1000);
      checkOutput("c_dlv0", qget(dlv_log, 0), 32'h4);
      checkOutput("c_dlv1", qget(dlv_log, 1), 32'h1004);
      checkOutput("c_ir1", qget(dlv_ir_log, 1), 32'h5A5A_B5A5);

      // Address wrap at the top of the address space
      doReset(2);
      doBranch(32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b0, 32'd0, 8);
      k = first_req_after(br_cyc);
      checkOutput("d_req_top", qget(req_log, k), 32'hFFFF_FFFC);
      checkOutput("d_req_wrap", qget(req_log, k + 1), 32'h0);
      checkOutput("d_dlv_wrap", qget(dlv_log, 1), 32'h0);
      checkOutput("d_dlv_next", qget(dlv_log, 2), 32'h4);
      checkOutput("d_ir_top", qget(dlv_ir_log, 1), 32'hA5A5_5A59);

      // Branch request while nothing is valid for decode is ignored
      doReset(2);
      applyStimulus(1'b1, 1'b1, 32'h0000_2000, 2);
      applyStimulus(1'b1, 1'b0, 32'd0, 8);
      checkOutput("e_req3", qget(req_log, 3), 32'hC);
      checkOutput("e_dlv0", qget(dlv_log, 0), 32'h4);
      checkOutput("e_dlv2", qget(dlv_log, 2), 32'hC);

      // Reset with two requests outstanding on a slow memory
      mem_lat = 4;
      doReset(2);
      applyStimulus(1'b1, 1'b0, 32'd0, 5);
      checkOutput("f_outstanding", 32'(req_log.size()), 32'd2);
      checkOutput("f_no_dlv_yet", 32'(dlv_log.size()), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("f_rst_id_valid", 32'(id_valid), 32'd0);
      checkOutput("f_rst_req_valid", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'd0, 14);
      checkOutput("f_restart_addr", qget(req_log, 0), RST_IA);
      checkOutput("f_restart_cycle", 32'(req_cyc_log.size() > 0 ? req_cyc_log[0] - rel_cyc : -1), 32'd1);
      checkOutput("f_dlv0", qget(dlv_log, 0), 32'h4);
      checkOutput("f_rsp_to_idv", 32'(first_idv_cyc - first_rsp_cyc), 32'(RSP_TO_IDV));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
